down_timer: RTL and testbench

- Loadable, enable-gated down-counting timer: the count-down counterpart to the project's up counter.
- Counts a programmed interval down to terminal count and flags expiry with a one-cycle TC pulse.
- Supports one-shot and periodic (auto-reload) modes, plus start/stop/resume control.
- Used by the CPU for delay/timeout generation and periodic tick events.

---
 rtl/down_timer.sv | 109 ++++++++++
 tb/tb_down_timer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// down_timer: loadable, enable-gated down-counting timer with one-shot and
// periodic (auto-reload) modes and start/stop/resume control. TC is a
// registered one-cycle pulse per expiry; BUSY decodes the RUN state directly.
module down_timer #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_,
    input  logic             EN,
    input  logic             LD,
    input  logic [WIDTH-1:0] DATA,
    input  logic             START,
    input  logic             STOP,
    input  logic             MODE,
    output logic [WIDTH-1:0] COUNT,
    output logic             TC,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    // Command decode: one action per edge, priority LD > STOP > START > count.
    // STOP outranks START even when it has nothing to pause, so a combined
    // START+STOP never starts the timer.
    logic do_load, do_stop, do_start_idle, do_start_done, do_count;
    logic count_is_zero, count_is_one, reload_is_zero;

    always_comb begin
        count_is_zero  = (count_q == ZERO);
        count_is_one   = (count_q == ONE);
        reload_is_zero = (reload_q == ZERO);

        do_load       = EN && LD;
        do_stop       = EN && !LD && STOP && (state_q == RUN);
        do_start_idle = EN && !LD && !STOP && START && (state_q == IDLE) && !count_is_zero;
        do_start_done = EN && !LD && !STOP && START && (state_q == DONE) && !reload_is_zero;
        do_count      = EN && !LD && !STOP && (state_q == RUN);
    end

    // Next-state computation for count, reload, state and the TC pulse.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (do_load) begin
            count_d  = DATA;
            reload_d = DATA;
            state_d  = IDLE;
        end else if (do_stop) begin
            // Pause: the count is kept so a later START resumes from it.
            state_d = IDLE;
        end else if (do_start_idle) begin
            // Entering RUN does not decrement; the first decrement is next edge.
            state_d = RUN;
        end else if (do_start_done) begin
            count_d = reload_q;
            state_d = RUN;
        end else if (do_count) begin
            if (count_is_one) begin
                // Expiry. MODE is sampled here, so a mid-run change lands now.
                tc_d = 1'b1;
                if (MODE) begin
                    count_d = reload_q;
                end else begin
                    count_d = ZERO;
                    state_d = DONE;
                end
            end else if (!count_is_zero) begin
                // Guard keeps the counter from wrapping even if RUN were
                // somehow entered with a zero count.
                count_d = count_q - ONE;
            end
        end
    end

    // State registers; async active-low reset clears everything, no TC.
    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign COUNT = count_q;
    assign TC    = tc_q;
    assign BUSY  = (state_q == RUN);

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: a behavioural reference predicts each
// edge's outputs into a scoreboard queue, which is popped after the edge.
// Directed constant checks from the intended sequences back it up.
module tb_down_timer;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST_ = 1'b0;
    logic         EN = 1'b0, LD = 1'b0, START = 1'b0, STOP = 1'b0, MODE = 1'b0;
    logic [W-1:0] DATA = '0;
    logic [W-1:0] COUNT;
    logic         TC, BUSY;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cnt;
        int tc;
        int busy;
    } exp_t;

    exp_t sb_q[$];

    // reference model state: 0 idle, 1 run, 2 done
    int m_st, m_cnt, m_rel, m_tc;

    down_timer #(.WIDTH(W)) dut (
        .CLK(CLK), .RST_(RST_), .EN(EN), .LD(LD), .DATA(DATA),
        .START(START), .STOP(STOP), .MODE(MODE),
        .COUNT(COUNT), .TC(TC), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_rel = 0; m_tc = 0;
    endtask

    // Reference: advances the model one edge for the given inputs.
    task automatic model_edge(input bit en, input bit ld, input int data,
                              input bit start, input bit stop, input bit mode);
        m_tc = 0;
        if (!en) return;
        if (ld) begin
            m_cnt = data; m_rel = data; m_st = 0;
            return;
        end
        case (m_st)
            0: if (start && !stop && m_cnt != 0) m_st = 1;
            2: if (start && !stop && m_rel != 0) begin m_cnt = m_rel; m_st = 1; end
            1: begin
                if (stop) m_st = 0;
                else if (m_cnt == 1) begin
                    m_tc = 1;
                    if (mode) m_cnt = m_rel;
                    else begin m_cnt = 0; m_st = 2; end
                end else m_cnt = m_cnt - 1;
            end
            default: ;
        endcase
    endtask

    // Drive one cycle of inputs, predict, clock, then compare after the edge.
    task automatic step(input bit en, input bit ld, input int data,
                        input bit start, input bit stop, input bit mode,
                        input string tag);
        exp_t e;
        EN = en; LD = ld; DATA = W'(data); START = start; STOP = stop; MODE = mode;
        model_edge(en, ld, data, start, stop, mode);
        e.cnt = m_cnt; e.tc = m_tc; e.busy = (m_st == 1) ? 1 : 0;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_cnt"}, int'(COUNT), e.cnt);
            chk({tag, "_tc"}, int'(TC), e.tc);
            chk({tag, "_busy"}, int'(BUSY), e.busy);
        end
    endtask

    task automatic idle_cyc(input bit mode, input string tag);
        step(1, 0, 0, 0, 0, mode, tag);
    endtask

    initial begin
        int seq5[5];
        int v;
        seq5 = '{4, 3, 2, 1, 0};
        model_reset();

        // 1: reset held two cycles, then START with COUNT = 0 is ignored
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_cnt", int'(COUNT), 0);
        chk("rst_tc", int'(TC), 0);
        chk("rst_busy", int'(BUSY), 0);
        RST_ = 1'b1;
        step(1, 0, 0, 1, 0, 0, "t1_start0");
        chk("t1_busy_const", int'(BUSY), 0);
        idle_cyc(0, "t1_idle");

        // 2: one-shot from 5
        step(1, 1, 5, 0, 0, 0, "t2_ld");
        step(1, 0, 0, 1, 0, 0, "t2_start");
        chk("t2_first_cnt", int'(COUNT), 5);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0, 0, "t2_run");
            chk("t2_seq", int'(COUNT), seq5[i]);
        end
        chk("t2_tc_at0", int'(TC), 1);
        chk("t2_busy_at0", int'(BUSY), 0);
        idle_cyc(0, "t2_done_hold");
        step(1, 0, 0, 1, 0, 0, "t2_restart");
        chk("t2_restart_cnt", int'(COUNT), 5);

        // 3: periodic with reload 3
        step(1, 1, 3, 0, 0, 1, "t3_ld");
        step(1, 0, 0, 1, 0, 1, "t3_start");
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0, 0, 1, "t3_run");
            v = 2 - (i % 3);
            if (v == 0) v = 3;
            chk("t3_seq", int'(COUNT), v);
            chk("t3_tc_pat", int'(TC), (i % 3 == 2) ? 1 : 0);
        end

        // periodic with reload 1: TC every cycle
        step(1, 1, 1, 0, 0, 1, "t3b_ld");
        step(1, 0, 0, 1, 0, 1, "t3b_start");
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 0, 1, "t3b_run");
            chk("t3b_tc_every", int'(TC), 1);
        end

        // 4: pause at 2, resume
        step(1, 1, 6, 0, 0, 0, "t4_ld");
        step(1, 0, 0, 1, 0, 0, "t4_start");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, "t4_run");
        chk("t4_at2", int'(COUNT), 2);
        step(1, 0, 0, 0, 1, 0, "t4_stop");
        chk("t4_stop_busy", int'(BUSY), 0);
        for (int i = 0; i < 4; i++) idle_cyc(0, "t4_idle");
        chk("t4_hold", int'(COUNT), 2);
        step(1, 0, 0, 1, 0, 0, "t4_resume");
        step(1, 0, 0, 0, 0, 0, "t4_r1");
        step(1, 0, 0, 0, 0, 0, "t4_r0");
        chk("t4_tc", int'(TC), 1);
        idle_cyc(0, "t4_after");

        // 5: EN low freezes mid-run; LD beats START
        step(1, 1, 7, 0, 0, 0, "t5_ld");
        step(1, 0, 0, 1, 0, 0, "t5_start");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, "t5_run");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, "t5_en_lo");
        chk("t5_frozen", int'(COUNT), 4);
        step(1, 1, 9, 1, 0, 0, "t5_ld_start");
        chk("t5_ld_cnt", int'(COUNT), 9);
        chk("t5_ld_busy", int'(BUSY), 0);

        // 6: async reset mid-run
        step(1, 1, 4, 0, 0, 0, "t6_ld");
        step(1, 0, 0, 1, 0, 0, "t6_start");
        step(1, 0, 0, 0, 0, 0, "t6_r3");
        step(1, 0, 0, 0, 0, 0, "t6_r2");
        #2;
        RST_ = 1'b0;
        model_reset();
        #1;
        chk("t6_async_cnt", int'(COUNT), 0);
        chk("t6_async_tc", int'(TC), 0);
        chk("t6_async_busy", int'(BUSY), 0);
        @(negedge CLK);
        RST_ = 1'b1;
        step(1, 0, 0, 1, 0, 0, "t6_start_ign");
        idle_cyc(0, "t6_idle");

        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
